sim_halt_ctrl: RTL and testbench
================================

# sim_halt_ctrl

Simulation halt controller for the NPC core's simulation top. It watches the commit stage for `ebreak` and classifies the exit as good or bad trap from `a0`. It stalls fetch and drains in-flight work for a fixed number of cycles, then presents a halt record to the DPI/testbench side over a valid/ack handshake. An optional no-commit watchdog ends hung runs with a timeout record.

## Interface
- `XLEN`, 32: width of PC and exit-code datapaths.
- `DRAIN_CYCLES`, 4: cycles held in DRAIN after `ebreak` commit before halting. 0 is legal.
- `WDT_CYCLES`, 1024: consecutive no-commit cycles that trigger timeout. Must be ≥2. Counter width is `$clog2(WDT_CYCLES)`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `commit_valid`  in  1  one instruction retires this cycle.
- `commit_ebreak`  in  1  retiring instruction is `ebreak`; qualified by `commit_valid`.
- `commit_pc`  in  XLEN  PC of retiring instruction.
- `a0`  in  XLEN  architectural x10 as seen at commit.
- `halt_ack`  in  1  testbench has consumed the halt record.
- `fetch_stall`  out  1  freeze fetch; registered.
- `halt_valid`  out  1  halt record valid; registered.
- `halt_reason`  out  2  0 none, 1 good trap, 2 bad trap, 3 timeout.
- `halt_code`  out  XLEN  exit code: captured `a0`, or all-ones on timeout.
- `halt_pc`  out  XLEN  PC of `ebreak`, or last committed PC on timeout.

## Operation
- States:
  - RUN: normal execution.
  - DRAIN: `ebreak` committed, waiting for in-flight work to finish.
  - HALT: record presented, waiting for ack.
  - DONE: terminal.
- RUN:
  - Each `commit_valid` updates the internal `last_pc` and clears the watchdog counter.
  - `commit_valid && commit_ebreak` captures `halt_pc=commit_pc` and `halt_code=a0`.
  - It also sets `halt_reason` to 1 if `a0==0`, else 2.
  - Next state is DRAIN, or HALT when `DRAIN_CYCLES==0`.
- DRAIN:
  - Down-counter loaded with `DRAIN_CYCLES-1`. Moves to HALT when it reaches 0.
  - `commit_valid` and `commit_ebreak` are ignored. The captured record is frozen.
  - Watchdog is inactive.
- HALT:
  - `halt_valid=1`; the record is stable.
  - On an edge with `halt_ack=1`, go to DONE.
- DONE:
  - `halt_valid=0`, `fetch_stall=1`, record retained.
  - Leaves only on reset.
- `fetch_stall` is 1 in DRAIN, HALT and DONE.
- `halt_ack` is ignored outside HALT.
- A second `ebreak` after the first is ignored.
- Watchdog (RUN only):
  - The counter increments each edge without `commit_valid`.
  - If the counter already equals `WDT_CYCLES-1` at an edge with no commit, capture `halt_reason=3`, `halt_code='1` and `halt_pc=last_pc`, then go directly to HALT with no drain.
  - A commit on that same edge wins: the counter clears, and an `ebreak` commit follows the normal path.
- Reset at any time:
  - State goes to RUN.
  - All counters and `last_pc` go to 0.
  - All outputs go to 0: `fetch_stall=0`, `halt_valid=0`, `halt_reason=0`, `halt_code=0`, `halt_pc=0`.

## Timing
- `ebreak` commit sampled at edge T:
  - `fetch_stall=1` from T+1.
  - `halt_valid=1` from T+1+`DRAIN_CYCLES`; with 0, from T+1.
- `halt_ack` sampled high at edge A while `halt_valid=1`: `halt_valid=0` from A+1. Ack may be held high early; the first HALT cycle then completes the handshake and `halt_valid` is high for exactly one cycle.
- Timeout: with the last commit (or reset release) at edge T, `halt_valid` and `fetch_stall` rise after edge T+`WDT_CYCLES`.
- No combinational path from any input to any output.

## Configuration
- `SIM_HALT_WDT_EN`:
  - Defined: watchdog counter and the timeout path are compiled in as described.
  - Undefined: no watchdog logic exists, and `halt_reason=3` is never produced. A hung core runs until an external limit stops it. All other behaviour is identical.

## Test plan
- Good trap: `DRAIN_CYCLES=4`, `ebreak` commits at pc 0x80000010 with `a0=0` at edge 10. Expect `fetch_stall` high from 11 and `halt_valid` high from 15 with reason 1, code 0, pc 0x80000010. Ack at 20 → `halt_valid` low from 21, `fetch_stall` stays 1.
- Bad trap: `ebreak` with `a0=0x2A`. Expect reason 2, code 0x2A. A second `ebreak` during DRAIN leaves the record unchanged.
- `DRAIN_CYCLES=0`: `ebreak` at edge 5 → `halt_valid` from 6. With ack held high throughout, `halt_valid` is high only during cycle 6.
- Watchdog (macro defined, `WDT_CYCLES=16`): last commit pc 0x80000100 at edge 3, then no commits. Expect `halt_valid` from edge 19 with reason 3, code 0xFFFFFFFF, pc 0x80000100. Repeat with a commit at edge 19: no halt.
- Reset mid-DRAIN: deassert `rst_n` asynchronously two cycles after `ebreak`. All outputs read 0 immediately. After release, a fresh `ebreak` yields a correct new record.
- Macro undefined: 5000 cycles without commit → `halt_valid` stays 0 and `halt_reason` is never 3.

Source files
------------

// File: rtl/sim_halt_ctrl.sv
// sim_halt_ctrl
//
// Halt controller for the NPC simulation top. It watches the commit stage for
// an ebreak and classifies the exit as a good trap (a0 == 0) or a bad trap
// (a0 != 0). After the ebreak it stalls fetch, lets in-flight work drain for
// DRAIN_CYCLES cycles, and then presents a halt record to the testbench side.
//
// Optional feature macro: SIM_HALT_WDT_EN
//   When defined, a no-commit watchdog is compiled in. After WDT_CYCLES
//   consecutive cycles without a commit in RUN, it emits a timeout record
//   (reason 3, code all-ones, pc = last committed PC).
//   When undefined, no watchdog logic exists and reason 3 is never produced.
//
// Handshake: halt_valid rises when the record is ready and stays high until an
// edge samples halt_ack high. That edge completes the transfer, and
// halt_valid is low from the next cycle on. halt_ack has no effect when
// halt_valid is low. If ack is already high, halt_valid is high for exactly
// one cycle.
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   commit_valid  in   one instruction retires this cycle
//   commit_ebreak in   retiring instruction is ebreak (qualified by commit_valid)
//   commit_pc     in   PC of retiring instruction
//   a0            in   architectural x10 at commit
//   halt_ack      in   testbench consumed the halt record
//   fetch_stall   out  freeze fetch (registered)
//   halt_valid    out  halt record valid (registered)
//   halt_reason   out  0 none, 1 good trap, 2 bad trap, 3 timeout
//   halt_code     out  captured a0, or all-ones on timeout
//   halt_pc       out  ebreak PC, or last committed PC on timeout
//
// The FSM state is held in the signal "state" for hierarchical observation.

module sim_halt_ctrl #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 4,
   parameter int WDT_CYCLES   = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid,
   input  logic            commit_ebreak,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] a0,
   input  logic            halt_ack,
   output logic            fetch_stall,
   output logic            halt_valid,
   output logic [1:0]      halt_reason,
   output logic [XLEN-1:0] halt_code,
   output logic [XLEN-1:0] halt_pc
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_HALT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Drain counter needs to hold DRAIN_CYCLES-1. Keep it at least 1 bit wide
   // so that DRAIN_CYCLES of 0 or 1 still elaborate cleanly.
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD =
      (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

   state_t          state, state_d;
   logic [DW-1:0]   drain_cnt, drain_cnt_d;
   logic            fetch_stall_d, halt_valid_d;
   logic [1:0]      reason_d;
   logic [XLEN-1:0] code_d, pc_d;

`ifdef SIM_HALT_WDT_EN
   localparam int WW = $clog2(WDT_CYCLES);
   localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

   logic [WW-1:0]   wdt_cnt, wdt_cnt_d;
   logic [XLEN-1:0] last_pc, last_pc_d;
`endif

   always_comb begin
      state_d     = state;
      drain_cnt_d = drain_cnt;
      reason_d    = halt_reason;
      code_d      = halt_code;
      pc_d        = halt_pc;
`ifdef SIM_HALT_WDT_EN
      wdt_cnt_d   = wdt_cnt;
      last_pc_d   = last_pc;
`endif

      case (state)
         S_RUN: begin
`ifdef SIM_HALT_WDT_EN
            // A commit on the expiry edge wins over the timeout.
            if (commit_valid) begin
               wdt_cnt_d = '0;
               last_pc_d = commit_pc;
            end else if (wdt_cnt == WDT_LAST) begin
               reason_d = 2'd3;
               code_d   = '1;
               pc_d     = last_pc;
               state_d  = S_HALT;
            end else begin
               wdt_cnt_d = wdt_cnt + 1'b1;
            end
`endif
            if (commit_valid && commit_ebreak) begin
               pc_d        = commit_pc;
               code_d      = a0;
               reason_d    = (a0 == '0) ? 2'd1 : 2'd2;
               drain_cnt_d = DRAIN_LOAD;
               state_d     = (DRAIN_CYCLES == 0) ? S_HALT : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == '0) begin
               state_d = S_HALT;
            end else begin
               drain_cnt_d = drain_cnt - 1'b1;
            end
         end
         S_HALT: begin
            if (halt_ack) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      // Outputs come straight from flops, so they are derived from the next state.
      fetch_stall_d = (state_d != S_RUN);
      halt_valid_d  = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RUN;
         drain_cnt   <= '0;
         fetch_stall <= 1'b0;
         halt_valid  <= 1'b0;
         halt_reason <= 2'd0;
         halt_code   <= '0;
         halt_pc     <= '0;
      end else begin
         state       <= state_d;
         drain_cnt   <= drain_cnt_d;
         fetch_stall <= fetch_stall_d;
         halt_valid  <= halt_valid_d;
         halt_reason <= reason_d;
         halt_code   <= code_d;
         halt_pc     <= pc_d;
      end
   end

`ifdef SIM_HALT_WDT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt <= '0;
         last_pc <= '0;
      end else begin
         wdt_cnt <= wdt_cnt_d;
         last_pc <= last_pc_d;
      end
   end
`endif

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// Bench for sim_halt_ctrl. Two instances share clock, reset and commit
// inputs: u_dut (DRAIN_CYCLES=4) acknowledges under bench control, and u_dut0
// (DRAIN_CYCLES=0) has halt_ack held high throughout. Both use WDT_CYCLES=16.
// Edge numbering: edge 1 is the first rising edge after reset release.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_sim_halt_ctrl;

   localparam int XLEN  = 32;
   localparam int REC_W = 2 + 2 * XLEN;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            commit_valid, commit_ebreak;
   logic [XLEN-1:0] commit_pc, a0;
   logic            halt_ack, halt_ack0;

   logic            fetch_stall, halt_valid;
   logic [1:0]      halt_reason;
   logic [XLEN-1:0] halt_code, halt_pc;
   logic            fetch_stall0, halt_valid0;
   logic [1:0]      halt_reason0;
   logic [XLEN-1:0] halt_code0, halt_pc0;

   // Expected halt records {reason, code, pc}: one queue per instance.
   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] exp0_q[$];

   int n_vec = 0;
   int n_err = 0;

   sim_halt_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(4), .WDT_CYCLES(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_ebreak(commit_ebreak),
      .commit_pc(commit_pc), .a0(a0), .halt_ack(halt_ack),
      .fetch_stall(fetch_stall), .halt_valid(halt_valid),
      .halt_reason(halt_reason), .halt_code(halt_code), .halt_pc(halt_pc)
   );

   sim_halt_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(0), .WDT_CYCLES(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_ebreak(commit_ebreak),
      .commit_pc(commit_pc), .a0(a0), .halt_ack(halt_ack0),
      .fetch_stall(fetch_stall0), .halt_valid(halt_valid0),
      .halt_reason(halt_reason0), .halt_code(halt_code0), .halt_pc(halt_pc0)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [REC_W-1:0] rec(input logic [1:0] r, input logic [XLEN-1:0] c,
                                            input logic [XLEN-1:0] p);
      return {r, c, p};
   endfunction

   // One commit sampled at the next edge; returns 1 unit after that edge.
   task automatic drive_commit(input logic eb, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] v);
      commit_valid  = 1'b1;
      commit_ebreak = eb;
      commit_pc     = pc;
      a0            = v;
      step(1);
      commit_valid  = 1'b0;
      commit_ebreak = 1'b0;
   endtask

   // Pop the next expected record for an instance and compare with its outputs.
   task automatic sb_pop(input bit which, input string tag);
      logic [REC_W-1:0] e;
      logic             v;
      logic [1:0]       r;
      logic [XLEN-1:0]  c, p;
      int               sz;
      if (which) begin
         v = halt_valid0; r = halt_reason0; c = halt_code0; p = halt_pc0; sz = exp0_q.size();
      end else begin
         v = halt_valid;  r = halt_reason;  c = halt_code;  p = halt_pc;  sz = exp_q.size();
      end
      check({tag, ".qsize"}, 64'(sz), 64'd1);
      if (sz > 0) begin
         e = which ? exp0_q.pop_front() : exp_q.pop_front();
         check({tag, ".valid"},  64'(v), 64'd1);
         check({tag, ".reason"}, 64'(r), 64'(e[REC_W-1 -: 2]));
         check({tag, ".code"},   64'(c), 64'(e[2*XLEN-1 -: XLEN]));
         check({tag, ".pc"},     64'(p), 64'(e[XLEN-1:0]));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ctl"},   64'({fetch_stall, halt_valid, halt_reason}), 64'd0);
      check({tag, ".code"},  64'(halt_code), 64'd0);
      check({tag, ".pc"},    64'(halt_pc), 64'd0);
      check({tag, ".ctl0"},  64'({fetch_stall0, halt_valid0, halt_reason0}), 64'd0);
      check({tag, ".code0"}, 64'(halt_code0), 64'd0);
      check({tag, ".pc0"},   64'(halt_pc0), 64'd0);
   endtask

   // Assert reset between edges, check outputs, release 1 unit after an edge.
   task automatic do_reset(input string tag);
      halt_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero(tag);
      step(1);
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n         = 1'b0;
      commit_valid  = 1'b0;
      commit_ebreak = 1'b0;
      commit_pc     = '0;
      a0            = '0;
      halt_ack      = 1'b0;
      halt_ack0     = 1'b1;
      step(2);
      check_zero("por");
      rst_n = 1'b1;

      // Good trap: ebreak at edge 10, pc 0x80000010, a0 = 0
      do_reset("rst_a");
      step(9);
      exp_q.push_back(rec(2'd1, 32'h0, 32'h8000_0010));
      exp0_q.push_back(rec(2'd1, 32'h0, 32'h8000_0010));
      drive_commit(1'b1, 32'h8000_0010, 32'h0);
      check("a.stall_t1", 64'(fetch_stall), 64'd1);
      check("a.valid_t1", 64'(halt_valid), 64'd0);
      sb_pop(1'b1, "a.d0");
      step(1);
      check("a.d0_one_cycle", 64'({halt_valid0, fetch_stall0}), 64'b01);
      step(2);
      check("a.valid_e13", 64'(halt_valid), 64'd0);
      step(1);
      sb_pop(1'b0, "a.halt");
      step(5);
      check("a.hold_e19", 64'({halt_valid, halt_reason}), 64'b101);
      halt_ack = 1'b1;
      step(1);
      halt_ack = 1'b0;
      check("a.ack_valid", 64'({halt_valid, fetch_stall}), 64'b01);
      check("a.ack_pc", 64'(halt_pc), 64'h8000_0010);
      drive_commit(1'b1, 32'h8000_0099, 32'h7);
      step(3);
      check("a.done_hold", 64'({halt_valid, fetch_stall, halt_reason}), 64'b0101);
      check("a.done_code", 64'(halt_code), 64'd0);

      // Bad trap, second ebreak during DRAIN ignored
      do_reset("rst_b");
      step(3);
      exp_q.push_back(rec(2'd2, 32'h2A, 32'h8000_0200));
      exp0_q.push_back(rec(2'd2, 32'h2A, 32'h8000_0200));
      drive_commit(1'b1, 32'h8000_0200, 32'h2A);
      sb_pop(1'b1, "b.d0");
      drive_commit(1'b1, 32'h8000_0300, 32'h0);
      step(2);
      check("b.valid_e_t3", 64'(halt_valid), 64'd0);
      step(1);
      sb_pop(1'b0, "b.halt");
      check("b.d0_code", 64'(halt_code0), 64'h2A);
      halt_ack = 1'b1;
      step(1);
      halt_ack = 1'b0;
      check("b.ack", 64'({halt_valid, fetch_stall}), 64'b01);

      // Reset mid-DRAIN, then a fresh ebreak
      do_reset("rst_c");
      step(2);
      exp0_q.push_back(rec(2'd2, 32'h5, 32'h8000_0400));
      drive_commit(1'b1, 32'h8000_0400, 32'h5);
      sb_pop(1'b1, "c.d0");
      step(2);
      check("c.drain_stall", 64'({fetch_stall, halt_valid}), 64'b10);
      #2 rst_n = 1'b0;
      #1 check_zero("c.async");
      step(1);
      rst_n = 1'b1;
      step(1);
      exp_q.push_back(rec(2'd1, 32'h0, 32'h8000_0500));
      exp0_q.push_back(rec(2'd1, 32'h0, 32'h8000_0500));
      drive_commit(1'b1, 32'h8000_0500, 32'h0);
      sb_pop(1'b1, "c.d0_new");
      step(3);
      check("c.valid_e_t3", 64'(halt_valid), 64'd0);
      step(1);
      sb_pop(1'b0, "c.halt_new");
      halt_ack = 1'b1;
      step(1);
      halt_ack = 1'b0;

`ifdef SIM_HALT_WDT_EN
      // Watchdog: last commit at edge 3, timeout visible after edge 19
      do_reset("rst_d");
      step(2);
      exp_q.push_back(rec(2'd3, 32'hFFFF_FFFF, 32'h8000_0100));
      exp0_q.push_back(rec(2'd3, 32'hFFFF_FFFF, 32'h8000_0100));
      drive_commit(1'b0, 32'h8000_0100, 32'h77);
      step(15);
      check("d.e18", 64'({halt_valid, fetch_stall, halt_valid0, fetch_stall0}), 64'd0);
      step(1);
      sb_pop(1'b0, "d.to");
      sb_pop(1'b1, "d.to0");
      check("d.stall", 64'(fetch_stall), 64'd1);
      halt_ack = 1'b1;
      step(1);
      halt_ack = 1'b0;

      // Commit on the expiry edge wins; next timeout 16 edges later
      do_reset("rst_e");
      step(2);
      drive_commit(1'b0, 32'h8000_0100, 32'h0);
      step(15);
      drive_commit(1'b0, 32'h8000_0104, 32'h0);
      check("e.e19", 64'({halt_valid, fetch_stall, halt_valid0, fetch_stall0}), 64'd0);
      exp_q.push_back(rec(2'd3, 32'hFFFF_FFFF, 32'h8000_0104));
      exp0_q.push_back(rec(2'd3, 32'hFFFF_FFFF, 32'h8000_0104));
      step(15);
      check("e.e34", 64'({halt_valid, fetch_stall}), 64'd0);
      step(1);
      sb_pop(1'b0, "e.to");
      sb_pop(1'b1, "e.to0");
`else
      // No watchdog: a long idle stretch never halts
      do_reset("rst_n_wdt");
      for (int i = 0; i < 5000; i++) begin
         step(1);
         check("nowdt", 64'({halt_valid, halt_reason == 2'd3, fetch_stall,
                             halt_valid0, halt_reason0 == 2'd3, fetch_stall0}), 64'd0);
      end
`endif

      check("sb.leftover", 64'(exp_q.size() + exp0_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
